// File: rtl/alu_flag_cond_unit.sv
// ALU consumer stage: NZCV flag register, condition evaluation, one-entry valid/ready output and saturating stats.
// Optional macro ALU_STICKY_OVF_EN adds a sticky overflow flag with its clear input.
module alu_flag_cond_unit #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [N-1:0]     result_i,
    input  logic [3:0]       alu_flags_i,
    input  logic             flag_we_i,
    input  logic [3:0]       cond_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [N-1:0]     result_o,
    output logic [3:0]       flags_o,
    output logic             cond_pass_o,
    output logic [CNT_W-1:0] op_count_o,
    output logic [CNT_W-1:0] ovf_count_o
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic             clr_sticky_i,
    output logic             sticky_ovf_o
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [N-1:0]     result_reg;
    logic [3:0]       flags_reg;
    logic             cond_pass_reg;
    logic [15:0]      cond_vec;
    logic             cond_pass_next;
    logic             accept;
    logic             drain;
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    logic flag_n, flag_z, flag_c, flag_v;
    assign flag_n = flags_reg[3];
    assign flag_z = flags_reg[2];
    assign flag_c = flags_reg[1];
    assign flag_v = flags_reg[0];

    // Conditions are judged against the flags as they stand before this operation writes them.
    always_comb begin
        cond_vec        = 16'h0000;
        cond_vec[4'h0]  = flag_z;
        cond_vec[4'h1]  = !flag_z;
        cond_vec[4'h2]  = flag_c;
        cond_vec[4'h3]  = !flag_c;
        cond_vec[4'h4]  = flag_n;
        cond_vec[4'h5]  = !flag_n;
        cond_vec[4'h6]  = flag_v;
        cond_vec[4'h7]  = !flag_v;
        cond_vec[4'h8]  = flag_c && !flag_z;
        cond_vec[4'h9]  = !flag_c || flag_z;
        cond_vec[4'hA]  = (flag_n == flag_v);
        cond_vec[4'hB]  = (flag_n != flag_v);
        cond_vec[4'hC]  = !flag_z && (flag_n == flag_v);
        cond_vec[4'hD]  = flag_z || (flag_n != flag_v);
        cond_vec[4'hE]  = 1'b1;
        cond_vec[4'hF]  = 1'b1;
    end

    assign cond_pass_next = cond_vec[cond_i];

    // In FULL the stage accepts only when it is being drained in the same cycle.
    assign ready_o = !rst_i && ((state_reg == EMPTY) || ready_i);
    assign valid_o = (state_reg == FULL);
    assign accept  = valid_i && ready_o;
    assign drain   = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= EMPTY;
            result_reg    <= '0;
            flags_reg     <= 4'b0000;
            cond_pass_reg <= 1'b0;
        end else if (accept) begin
            state_reg     <= FULL;
            result_reg    <= result_i;
            cond_pass_reg <= cond_pass_next;
            if (flag_we_i && cond_pass_next) begin
                flags_reg <= alu_flags_i;
            end
        end else if (drain) begin
            state_reg <= EMPTY;
        end
    end

    assign cnt_inc = {accept && cond_pass_next && alu_flags_i[0], accept && cond_pass_next};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign result_o    = result_reg;
    assign flags_o     = flags_reg;
    assign cond_pass_o = cond_pass_reg;
    assign op_count_o  = cnt_reg[0];
    assign ovf_count_o = cnt_reg[1];

`ifdef ALU_STICKY_OVF_EN
    logic sticky_reg;

    // A new overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_reg <= 1'b0;
        end else if (cnt_inc[1]) begin
            sticky_reg <= 1'b1;
        end else if (clr_sticky_i) begin
            sticky_reg <= 1'b0;
        end
    end

    assign sticky_ovf_o = sticky_reg;
`endif

endmodule

// File: tb/tb_alu_flag_cond_unit.sv
// Scoreboard bench for alu_flag_cond_unit (CNT_W=2 so saturation is reachable).
// Directed vectors push hand-computed expectations; a monitor checks each drained entry.
module tb_alu_flag_cond_unit;

    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [N-1:0]     result_i;
    logic [3:0]       alu_flags_i;
    logic             flag_we_i;
    logic [3:0]       cond_i;
    logic             valid_o;
    logic             ready_i;
    logic [N-1:0]     result_o;
    logic [3:0]       flags_o;
    logic             cond_pass_o;
    logic [CNT_W-1:0] op_count_o;
    logic [CNT_W-1:0] ovf_count_o;
`ifdef ALU_STICKY_OVF_EN
    logic             clr_sticky_i;
    logic             sticky_ovf_o;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]     res;
        logic [3:0]       flags;
        logic             pass;
        logic [CNT_W-1:0] op;
        logic [CNT_W-1:0] ovf;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    alu_flag_cond_unit #(.N(N), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .result_i    (result_i),
        .alu_flags_i (alu_flags_i),
        .flag_we_i   (flag_we_i),
        .cond_i      (cond_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .flags_o     (flags_o),
        .cond_pass_o (cond_pass_o),
        .op_count_o  (op_count_o),
        .ovf_count_o (ovf_count_o)
`ifdef ALU_STICKY_OVF_EN
        ,
        .clr_sticky_i(clr_sticky_i),
        .sticky_ovf_o(sticky_ovf_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: an entry is consumed when valid_o and ready_i are both high at the coming edge.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_o", 32'(result_o), 32'(e.res));
                chk("flags_o", 32'(flags_o), 32'(e.flags));
                chk("cond_pass_o", 32'(cond_pass_o), 32'(e.pass));
                chk("op_count_o", 32'(op_count_o), 32'(e.op));
                chk("ovf_count_o", 32'(ovf_count_o), 32'(e.ovf));
                $display("drain res=%h flags=%b pass=%b op=%0d ovf=%0d",
                         result_o, flags_o, cond_pass_o, op_count_o, ovf_count_o);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [3:0] res, input logic [3:0] fl, input logic we,
                         input logic [3:0] cond, input logic [3:0] e_fl, input logic e_pass,
                         input int e_op, input int e_ovf);
        exp_t e;
        bit   accepted;
        e.res   = res;
        e.flags = e_fl;
        e.pass  = e_pass;
        e.op    = CNT_W'(e_op);
        e.ovf   = CNT_W'(e_ovf);
        valid_i     = 1'b1;
        result_i    = res;
        alu_flags_i = fl;
        flag_we_i   = we;
        cond_i      = cond;
        accepted    = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                exp_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        $display("issue res=%h flags=%b we=%b cond=%h", res, fl, we, cond);
        valid_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        valid_i      = 1'b1;
        ready_i      = 1'b1;
        result_i     = 4'hF;
        alu_flags_i  = 4'hF;
        flag_we_i    = 1'b1;
        cond_i       = 4'hE;
`ifdef ALU_STICKY_OVF_EN
        clr_sticky_i = 1'b0;
`endif

        // Reset held for two cycles with valid_i asserted.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("rst_ready_o", 32'(ready_o), 32'd0);
            chk("rst_valid_o", 32'(valid_o), 32'd0);
            chk("rst_flags_o", 32'(flags_o), 32'd0);
            chk("rst_op_count", 32'(op_count_o), 32'd0);
            chk("rst_ovf_count", 32'(ovf_count_o), 32'd0);
            $display("reset cycle %0d ready=%b valid=%b", c, ready_o, valid_o);
        end
`ifdef ALU_STICKY_OVF_EN
        chk("rst_sticky", 32'(sticky_ovf_o), 32'd0);
`endif
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_ready_o", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Unconditional op writes flags 1000.
        issue(4'h8, 4'b1000, 1'b1, 4'hE, 4'b1000, 1'b1, 1, 0);
        chk("latency_valid_o", 32'(valid_o), 32'd1);
        repeat (2) @(posedge clk_i);
        #1;

        // EQ fails (Z=0): result captured, flags untouched, count unchanged; hold under backpressure.
        ready_i = 1'b0;
        issue(4'h5, 4'b0100, 1'b1, 4'h0, 4'b1000, 1'b0, 1, 0);
        valid_i     = 1'b1;
        result_i    = 4'h3;
        alu_flags_i = 4'b0000;
        flag_we_i   = 1'b0;
        cond_i      = 4'hE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("bp_ready_o", 32'(ready_o), 32'd0);
            chk("bp_result_o", 32'(result_o), 32'h5);
            chk("bp_flags_o", 32'(flags_o), 32'b1000);
            chk("bp_valid_o", 32'(valid_o), 32'd1);
            $display("backpressure cycle %0d ready=%b res=%h", c, ready_o, result_o);
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        issue(4'h3, 4'b0000, 1'b0, 4'hE, 4'b1000, 1'b1, 2, 0);
        chk("bp_reload_valid_o", 32'(valid_o), 32'd1);
        chk("bp_reload_result_o", 32'(result_o), 32'h3);

        // Back-to-back V=1 passes: counters saturate at 3.
        issue(4'h1, 4'b0001, 1'b1, 4'hE, 4'b0001, 1'b1, 3, 1);
        issue(4'h2, 4'b0001, 1'b1, 4'hE, 4'b0001, 1'b1, 3, 2);
        issue(4'h3, 4'b0001, 1'b1, 4'hE, 4'b0001, 1'b1, 3, 3);
        issue(4'h4, 4'b0001, 1'b1, 4'hE, 4'b0001, 1'b1, 3, 3);
        issue(4'h5, 4'b0001, 1'b1, 4'hE, 4'b0001, 1'b1, 3, 3);
`ifdef ALU_STICKY_OVF_EN
        chk("sticky_set", 32'(sticky_ovf_o), 32'd1);
`endif

        // Load N=1,V=1, then signed and mixed conditions without flag writes.
        issue(4'h6, 4'b1001, 1'b1, 4'hE, 4'b1001, 1'b1, 3, 3);
`ifdef ALU_STICKY_OVF_EN
        clr_sticky_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_sticky_i = 1'b0;
        chk("sticky_clr", 32'(sticky_ovf_o), 32'd0);
`endif
        issue(4'h7, 4'b0000, 1'b0, 4'hA, 4'b1001, 1'b1, 3, 3);
        issue(4'h8, 4'b0001, 1'b0, 4'hB, 4'b1001, 1'b0, 3, 3);
        issue(4'h9, 4'b0000, 1'b0, 4'h8, 4'b1001, 1'b0, 3, 3);
        issue(4'hA, 4'b0000, 1'b0, 4'hD, 4'b1001, 1'b0, 3, 3);
        issue(4'hB, 4'b0000, 1'b0, 4'hC, 4'b1001, 1'b1, 3, 3);
        issue(4'hC, 4'b0000, 1'b0, 4'h4, 4'b1001, 1'b1, 3, 3);
        issue(4'hD, 4'b0000, 1'b0, 4'hF, 4'b1001, 1'b1, 3, 3);
`ifdef ALU_STICKY_OVF_EN
        chk("sticky_fail_no_set", 32'(sticky_ovf_o), 32'd0);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk_i);
        end
        @(negedge clk_i);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_valid_o", 32'(valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
